// File: rtl/key_led_ctrl.sv
// rtl/key_led_ctrl.sv - two-key debounced up/down counter driving four LEDs
// A key held through reset must be seen released before it can register a press.

module key_debounce #(
   parameter int CNT_MAX = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic press
);
   localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   typedef enum logic [1:0] {IDLE, FILT_DN, DOWN, FILT_UP} state_t;

   state_t        state, state_nxt;
   logic [1:0]    sync;
   logic [1:0]    vld;
   logic          armed;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          press_nxt;
   logic          key_s;

   assign key_s = sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= 2'b11;
         vld   <= 2'b00;
         armed <= 1'b0;
         state <= IDLE;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], key};
         vld   <= {vld[0], 1'b1};
         // vld marks when sync[1] holds a real sample rather than its reset value
         if (vld[1] && key_s)
            armed <= 1'b1;
         state <= state_nxt;
         cnt   <= cnt_nxt;
         press <= press_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (!key_s && armed) begin
               state_nxt = FILT_DN;
               cnt_nxt   = '0;
            end
         end
         FILT_DN: begin
            if (key_s) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = DOWN;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DOWN: begin
            if (key_s) begin
               state_nxt = FILT_UP;
               cnt_nxt   = '0;
            end
         end
         FILT_UP: begin
            if (!key_s) begin
               state_nxt = DOWN;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

module key_led_ctrl #(
   parameter int CNT_MAX = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in0,
   input  logic       key_in1,
   output logic [3:0] led
);
   logic press0, press1;

   key_debounce #(.CNT_MAX(CNT_MAX)) u_key0 (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (key_in0),
      .press (press0)
   );

   key_debounce #(.CNT_MAX(CNT_MAX)) u_key1 (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (key_in1),
      .press (press1)
   );

   // Simultaneous up and down presses cancel out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= 4'b0000;
      end else begin
         case ({press1, press0})
            2'b01:   led <= led + 4'd1;
            2'b10:   led <= led - 4'd1;
            default: led <= led;
         endcase
      end
   end
endmodule

// File: tb/tb_key_led_ctrl.sv
// tb/tb_key_led_ctrl.sv - directed table-driven bench for key_led_ctrl
module tb_key_led_ctrl;
   localparam int CNT_MAX = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_in0 = 1'b1;
   logic       key_in1 = 1'b1;
   logic [3:0] led;

   int n_cmp = 0;
   int n_err = 0;

   key_led_ctrl #(.CNT_MAX(CNT_MAX)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_in0 (key_in0),
      .key_in1 (key_in1),
      .led     (led)
   );

   always #10 clk = ~clk;

   typedef struct {
      string    name;
      bit       k0;
      bit       k1;
      int       hold;
      bit       bounce;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[10];
   int   bounce_dn[6] = '{5, 3, 8, 2, 12, 4};
   int   bounce_up[4] = '{4, 6, 3, 9};

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: led=%h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit k0, input bit k1, input logic lvl);
      key_in0 = k0 ? lvl : 1'b1;
      key_in1 = k1 ? lvl : 1'b1;
   endtask

   task automatic apply(input bit k0, input bit k1, input int hold, input bit bounce);
      if (bounce) begin
         for (int i = 0; i < 6; i++) begin
            drive(k0, k1, (i % 2 == 0) ? 1'b0 : 1'b1);
            tick(bounce_dn[i]);
         end
      end
      drive(k0, k1, 1'b0);
      tick(hold);
      if (bounce) begin
         for (int i = 0; i < 4; i++) begin
            drive(k0, k1, (i % 2 == 0) ? 1'b1 : 1'b0);
            tick(bounce_up[i]);
         end
      end
      drive(k0, k1, 1'b1);
      tick(CNT_MAX + 20);
   endtask

   initial begin
      vecs[0] = '{"k0_clean",     1'b1, 1'b0, 200,   1'b0, 4'h1};
      vecs[1] = '{"k1_bounce",    1'b0, 1'b1, 200,   1'b1, 4'h0};
      vecs[2] = '{"k1_wrap_down", 1'b0, 1'b1, 200,   1'b0, 4'hF};
      vecs[3] = '{"k0_wrap_up",   1'b1, 1'b0, 200,   1'b1, 4'h0};
      vecs[4] = '{"k0_glitch99",  1'b1, 1'b0, 99,    1'b0, 4'h0};
      vecs[5] = '{"both_keys",    1'b1, 1'b1, 300,   1'b0, 4'h0};
      vecs[6] = '{"k0_bounce",    1'b1, 1'b0, 150,   1'b1, 4'h1};
      vecs[7] = '{"k1_glitch50",  1'b0, 1'b1, 50,    1'b0, 4'h1};
      vecs[8] = '{"k0_hold_long", 1'b1, 1'b0, 10000, 1'b0, 4'h2};
      vecs[9] = '{"k1_clean",     1'b0, 1'b1, 300,   1'b0, 4'h1};

      rst_n = 1'b0;
      tick(5);
      check("reset_during", led, 4'h0);
      tick(5);
      rst_n = 1'b1;
      tick(1000);
      check("reset_idle", led, 4'h0);

      for (int v = 0; v < 10; v++) begin
         apply(vecs[v].k0, vecs[v].k1, vecs[v].hold, vecs[v].bounce);
         check(vecs[v].name, led, vecs[v].exp);
      end

      // Press latency from the first sampling edge, with one cycle of slack each way
      key_in0 = 1'b0;
      for (int i = 1; i <= 105; i++) begin
         tick(1);
         if (i == 102) check("latency_early", led, 4'h1);
         if (i == 105) check("latency_done", led, 4'h2);
      end
      tick(200);
      key_in0 = 1'b1;
      tick(CNT_MAX + 20);
      check("latency_no_repeat", led, 4'h2);

      // Reset in the middle of the down filter with the key still held
      key_in0 = 1'b0;
      tick(50);
      rst_n = 1'b0;
      tick(3);
      check("midfilt_reset", led, 4'h0);
      rst_n = 1'b1;
      tick(500);
      check("held_after_reset", led, 4'h0);
      key_in0 = 1'b1;
      tick(CNT_MAX + 20);
      check("released_after_reset", led, 4'h0);
      apply(1'b1, 1'b0, 200, 1'b0);
      check("press_after_reset", led, 4'h1);

      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(20);
      for (int i = 0; i < 16; i++) begin
         logic [3:0] e;
         e = 4'((i + 1) % 16);
         apply(1'b1, 1'b0, 150, 1'b0);
         check($sformatf("wrap_step%0d", i), led, e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/key_led_ctrl.md
# key_led_ctrl

Two-key LED counter for the board-level key demo. It synchronises and debounces two active-low mechanical push-buttons. Each confirmed press of key 0 increments a 4-bit value shown on four LEDs, and each confirmed press of key 1 decrements it. The block sits directly between the board key pins and the LED pins. The clock is the 50 MHz board oscillator (20 ns period).

## Interface
Parameters:
- `CNT_MAX`, default 1_000_000: debounce stability window in clock cycles (20 ms at 50 MHz). The bench may override it to a small value (e.g. 100).

Ports:
- `clk` input, 1 bit: system clock, 50 MHz, rising-edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `key_in0` input, 1 bit: raw key 0, active-low (idle = 1), asynchronous and bouncing.
- `key_in1` input, 1 bit: raw key 1, active-low (idle = 1), asynchronous and bouncing.
- `led` output, 4 bits: current count; bit = 1 means the LED is lit.

## Operation
- **Per-key input path:** identical and independent for both keys.
  - A 2-flop synchroniser feeds a debounce FSM.
  - The synchroniser flops reset to 1.
- **Debounce FSM:** states IDLE, FILT_DN, DOWN, FILT_UP; reset state is IDLE. A counter `cnt` of width ceil(log2(CNT_MAX)) is used.
  - IDLE: on synced input = 0, go to FILT_DN and clear `cnt`.
  - FILT_DN: while input = 0, increment `cnt`. If input = 1 before `cnt` reaches CNT_MAX-1, return to IDLE (bounce rejected). When `cnt` = CNT_MAX-1, go to DOWN and assert a one-cycle `press` pulse.
  - DOWN: on input = 1, go to FILT_UP and clear `cnt`.
  - FILT_UP: while input = 1, increment `cnt`. If input = 0 before `cnt` reaches CNT_MAX-1, return to DOWN. When `cnt` = CNT_MAX-1, return to IDLE. No pulse is generated on release.
- **LED register:** `led` is a 4-bit register.
  - press0 only: `led <= led + 1`, wrapping 4'hF → 4'h0.
  - press1 only: `led <= led - 1`, wrapping 4'h0 → 4'hF.
  - press0 and press1 in the same cycle: `led` unchanged.
- **Hold behaviour:** holding a key down produces exactly one event. There is no auto-repeat.
- **Reset:** asserting `rst_n` low at any time, including mid-filter, gives:
  - `led` = 4'b0000
  - both FSMs in IDLE
  - counters = 0
  - synchronisers = 1.
- **Bounce:** glitches shorter than CNT_MAX cycles never change `led`.

## Timing
- Reset value of `led` is 4'b0000.
- **Press latency:** measured from the first clock at which the raw key is sampled 0 and then stays 0.
  - 2 cycles through the synchroniser.
  - CNT_MAX cycles in FILT_DN.
  - 1 cycle for the `led` register.
  - Total: `led` changes CNT_MAX+3 cycles after the last bounce edge (±1 cycle for asynchronous sampling).
- A press shorter than CNT_MAX cycles after the last bounce produces no change.
- A new press is accepted only after the FSM has returned to IDLE. This requires release plus CNT_MAX stable-high cycles.
- All state updates happen on `clk` rising edges. `rst_n` acts immediately (asynchronously).

## Test plan
1. **Reset:** hold `rst_n`=0 for 10 cycles with keys idle high → `led` = 4'b0000 during and after reset; no change for 1000 idle cycles.
2. **Single key-0 press with bounce** (CNT_MAX=1_000_000, key model bouncing ~10 ms, held ~50 ms, release bounce; sim run of 100 ms after press) → `led` becomes 4'b0001 exactly once, about 20 ms after the bounce ends.
3. **Key-1 press from 4'b0001** (same stimulus on key 1, next 100 ms window) → `led` = 4'b0000. A second key-1 press → `led` = 4'b1111 (wrap).
4. **Glitch rejection** (CNT_MAX=100): key0 low for 99 cycles then high → `led` unchanged. Key0 low for 200 cycles → `led` +1 at CNT_MAX+3 cycles; holding low for 10_000 cycles gives no further increments.
5. **Wrap up:** 16 clean key-0 presses from reset → `led` steps 1..15 then 0.
6. **Simultaneous presses:** both keys falling together and held → `led` unchanged. Reset asserted mid-FILT_DN → `led` = 0, and no pulse after `rst_n` is released while the key is still held, until the key is released and pressed again.
